// File: rtl/ifetch_buffer_if.sv
// Fetch-to-decode buffer bus.
// Groups the fetch-side request/response signals, the flush redirect,
// the decoder handshake, and the two decode slots.
//   master : environment side (fetch stage, icache, decoder)
//   slave  : ifetch_buffer side
interface ifetch_buffer_if;
  logic         req_fire;
  logic [31:0]  req_pc;
  logic         data_ok;
  logic [255:0] rdata;
  logic [3:0]   rnum;
  logic         flush;
  logic [1:0]   de_ready;
  logic         fetch_allow;
  logic         out0_valid, out1_valid;
  logic [31:0]  out0_inst, out1_inst;
  logic [31:0]  out0_pc, out1_pc;

  modport master (
    output req_fire, req_pc, data_ok, rdata, rnum, flush, de_ready,
    input  fetch_allow, out0_valid, out1_valid, out0_inst, out1_inst,
           out0_pc, out1_pc
  );

  modport slave (
    input  req_fire, req_pc, data_ok, rdata, rnum, flush, de_ready,
    output fetch_allow, out0_valid, out1_valid, out0_inst, out1_inst,
           out0_pc, out1_pc
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer.
// A 32-entry circular FIFO of {inst, pc} sitting between the icache
// response and a dual-issue decoder. PCs of in-flight requests are held in
// a 2-entry queue; each returned block of up to 8 words is tagged with
// consecutive PCs starting at the oldest outstanding request PC.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : ifetch_buffer_if.slave (request/response, flush, decode slots)
module ifetch_buffer (
  input logic            clk,
  input logic            resetn,
  ifetch_buffer_if.slave bus
);
  logic [31:0] mem_inst [32];
  logic [31:0] mem_pc   [32];
  logic [4:0]  head, tail;
  logic [5:0]  count;
  logic [1:0]  pend, drop;
  logic [31:0] pcq [2];
  logic        pcq_rd, pcq_wr;

  logic [5:0]  free;
  logic [3:0]  n_clip, n_wr;
  logic [1:0]  n_rd, eff;
  logic [4:0]  head1;

  assign head1 = head + 5'd1;

  always_comb begin
    free   = 6'd32 - count;
    n_clip = (bus.rnum > 4'd8) ? 4'd8 : bus.rnum;
    n_wr   = 4'd0;
    // Stale responses (drop>0) and the flush cycle write nothing; never
    // write past the free space even if the fetch protocol was violated.
    if (bus.data_ok && drop == 2'd0 && !bus.flush)
      n_wr = ({2'b0, n_clip} > free) ? free[3:0] : n_clip;
    n_rd = 2'd0;
    if (!bus.flush)
      n_rd = {1'b0, bus.out0_valid & bus.de_ready[0]} +
             {1'b0, bus.out1_valid & (&bus.de_ready)};
    // Requests whose responses will actually land in the FIFO.
    eff = pend - drop;
  end

  // Reserve a full 8-word block of space for every live request plus the
  // one about to be issued.
  assign bus.fetch_allow = !bus.flush && eff < 2'd2 &&
                           ({1'b0, free} >= {2'b0, eff + 2'd1, 3'b000});

  assign bus.out0_valid = (count != 6'd0);
  assign bus.out1_valid = (count >= 6'd2);
  assign bus.out0_inst  = bus.out0_valid ? mem_inst[head]  : 32'd0;
  assign bus.out0_pc    = bus.out0_valid ? mem_pc[head]    : 32'd0;
  assign bus.out1_inst  = bus.out1_valid ? mem_inst[head1] : 32'd0;
  assign bus.out1_pc    = bus.out1_valid ? mem_pc[head1]   : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      pend   <= '0;
      drop   <= '0;
      pcq_rd <= 1'b0;
      pcq_wr <= 1'b0;
      pcq[0] <= '0;
      pcq[1] <= '0;
    end else begin
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + 5'(n_rd);
        tail  <= tail + 5'(n_wr);
        count <= count + 6'(n_wr) - 6'(n_rd);
      end
      // PC queue keeps tracking in-flight requests across a flush so the
      // stale responses still pop their own PCs.
      if (bus.req_fire) begin
        pcq[pcq_wr] <= bus.req_pc;
        pcq_wr      <= ~pcq_wr;
      end
      if (bus.data_ok) pcq_rd <= ~pcq_rd;
      pend <= pend + 2'(bus.req_fire) - 2'(bus.data_ok);
      // Every request still in flight after the flush cycle is stale.
      if (bus.flush)
        drop <= pend + 2'(bus.req_fire) - 2'(bus.data_ok);
      else if (bus.data_ok && drop != 2'd0)
        drop <= drop - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n_wr) begin
        mem_inst[tail + 5'(i)] <= bus.rdata[32*i +: 32];
        mem_pc[tail + 5'(i)]   <= pcq[pcq_rd] + 32'(4*i);
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ifetch_buffer_if bus ();
  ifetch_buffer dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic fire; logic [31:0] pc; logic ok; logic [3:0] rn; logic [31:0] base;
    logic [1:0] de; logic fl;
    logic v0; logic [31:0] i0; logic [31:0] p0;
    logic v1; logic [31:0] i1; logic [31:0] p1;
    logic [5:0] cnt; logic fa;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.req_fire = 1'b0; bus.req_pc = '0; bus.data_ok = 1'b0; bus.rdata = '0;
    bus.rnum = '0; bus.flush = 1'b0; bus.de_ready = 2'b00;
  endtask

  // One clock with the given inputs; returns #2 after the edge with inputs idle.
  task automatic cyc(input logic fire, input logic [31:0] pc, input logic ok,
                     input logic [3:0] rn, input logic [31:0] base,
                     input logic [1:0] de, input logic fl);
    logic [255:0] rd;
    for (int i = 0; i < 8; i++) rd[32*i +: 32] = base + 32'(i);
    bus.req_fire = fire; bus.req_pc = pc; bus.data_ok = ok; bus.rdata = rd;
    bus.rnum = rn; bus.de_ready = de; bus.flush = fl;
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  task automatic slots(input string tag, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    chk({tag, "_v0"}, 32'(bus.out0_valid), 32'd1);
    chk({tag, "_i0"}, bus.out0_inst, i0);
    chk({tag, "_p0"}, bus.out0_pc, p0);
    chk({tag, "_v1"}, 32'(bus.out1_valid), 32'd1);
    chk({tag, "_i1"}, bus.out1_inst, i1);
    chk({tag, "_p1"}, bus.out1_pc, p1);
  endtask

  initial begin
    //         fire pc            ok rn  base         de    fl  v0 i0           p0            v1 i1           p1            cnt fa
    vt[0]  = '{1, 32'hBFC00000, 0, 0, 32'h0,       2'b00, 0, 0, 32'h0,     32'h0,        0, 32'h0,     32'h0,        0, 1};
    vt[1]  = '{0, 32'h0,        1, 8, 32'h1000,    2'b00, 0, 1, 32'h1000,  32'hBFC00000, 1, 32'h1001,  32'hBFC00004, 8, 1};
    vt[2]  = '{0, 32'h0,        0, 0, 32'h0,       2'b01, 0, 1, 32'h1001,  32'hBFC00004, 1, 32'h1002,  32'hBFC00008, 7, 1};
    vt[3]  = '{0, 32'h0,        0, 0, 32'h0,       2'b11, 0, 1, 32'h1003,  32'hBFC0000C, 1, 32'h1004,  32'hBFC00010, 5, 1};
    vt[4]  = '{1, 32'h1014,     0, 0, 32'h0,       2'b11, 0, 1, 32'h1005,  32'hBFC00014, 1, 32'h1006,  32'hBFC00018, 3, 1};
    vt[5]  = '{0, 32'h0,        1, 3, 32'h2000,    2'b01, 0, 1, 32'h1006,  32'hBFC00018, 1, 32'h1007,  32'hBFC0001C, 5, 1};
    vt[6]  = '{0, 32'h0,        0, 0, 32'h0,       2'b10, 0, 1, 32'h1006,  32'hBFC00018, 1, 32'h1007,  32'hBFC0001C, 5, 1};
    vt[7]  = '{0, 32'h0,        0, 0, 32'h0,       2'b11, 0, 1, 32'h2000,  32'h1014,     1, 32'h2001,  32'h1018,     3, 1};
    vt[8]  = '{0, 32'h0,        0, 0, 32'h0,       2'b01, 0, 1, 32'h2001,  32'h1018,     1, 32'h2002,  32'h101C,     2, 1};
    vt[9]  = '{0, 32'h0,        0, 0, 32'h0,       2'b01, 0, 1, 32'h2002,  32'h101C,     0, 32'h0,     32'h0,        1, 1};
    vt[10] = '{0, 32'h0,        0, 0, 32'h0,       2'b01, 0, 0, 32'h0,     32'h0,        0, 32'h0,     32'h0,        0, 1};
    vt[11] = '{1, 32'h3000,     0, 0, 32'h0,       2'b00, 0, 0, 32'h0,     32'h0,        0, 32'h0,     32'h0,        0, 1};
    vt[12] = '{0, 32'h0,        1, 0, 32'h3300,    2'b00, 0, 0, 32'h0,     32'h0,        0, 32'h0,     32'h0,        0, 1};
    vt[13] = '{1, 32'h4000,     0, 0, 32'h0,       2'b00, 0, 0, 32'h0,     32'h0,        0, 32'h0,     32'h0,        0, 1};
    vt[14] = '{0, 32'h0,        1, 12, 32'h5000,   2'b00, 0, 1, 32'h5000,  32'h4000,     1, 32'h5001,  32'h4004,     8, 1};
    vt[15] = '{0, 32'h0,        0, 0, 32'h0,       2'b11, 1, 0, 32'h0,     32'h0,        0, 32'h0,     32'h0,        0, 1};

    idle();
    #1;
    chk("rst_v0", 32'(bus.out0_valid), 32'd0);
    chk("rst_v1", 32'(bus.out1_valid), 32'd0);
    chk("rst_i0", bus.out0_inst, 32'd0);
    chk("rst_p1", bus.out1_pc, 32'd0);
    chk("rst_cnt", 32'(dut.count), 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #2;
    chk("rst_fa", 32'(bus.fetch_allow), 32'd1);

    for (int k = 0; k < 16; k++) begin
      string t;
      t = $sformatf("vec%0d", k);
      cyc(vt[k].fire, vt[k].pc, vt[k].ok, vt[k].rn, vt[k].base, vt[k].de, vt[k].fl);
      chk({t, "_v0"}, 32'(bus.out0_valid), 32'(vt[k].v0));
      chk({t, "_i0"}, bus.out0_inst, vt[k].i0);
      chk({t, "_p0"}, bus.out0_pc, vt[k].p0);
      chk({t, "_v1"}, 32'(bus.out1_valid), 32'(vt[k].v1));
      chk({t, "_i1"}, bus.out1_inst, vt[k].i1);
      chk({t, "_p1"}, bus.out1_pc, vt[k].p1);
      chk({t, "_cnt"}, 32'(dut.count), 32'(vt[k].cnt));
      chk({t, "_fa"}, 32'(bus.fetch_allow), 32'(vt[k].fa));
    end

    // Fill to 24 with no consumer: space check for fetch_allow.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h100 * 32'(k), 0, 0, 0, 2'b00, 0);
      cyc(0, 0, 1, 8, 32'h7700 + 32'(16*k), 2'b00, 0);
    end
    chk("fill24_cnt", 32'(dut.count), 32'd24);
    chk("fill24_fa", 32'(bus.fetch_allow), 32'd1);
    cyc(1, 32'h400, 0, 0, 0, 2'b00, 0);
    chk("fill24_pend1_fa", 32'(bus.fetch_allow), 32'd0);
    cyc(0, 0, 0, 0, 0, 2'b11, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 0);
    chk("fill20_cnt", 32'(dut.count), 32'd20);
    chk("fill20_fa", 32'(bus.fetch_allow), 32'd0);
    cyc(0, 0, 1, 8, 32'h7800, 2'b00, 0);
    chk("fill28_cnt", 32'(dut.count), 32'd28);
    chk("fill28_fa", 32'(bus.fetch_allow), 32'd0);
    // Protocol-violating extra block: only the 4 free entries are written.
    cyc(1, 32'h500, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 1, 8, 32'h7900, 2'b00, 0);
    chk("ovf_cnt", 32'(dut.count), 32'd32);
    chk("ovf_fa", 32'(bus.fetch_allow), 32'd0);
    cyc(0, 0, 0, 0, 0, 2'b00, 1);
    chk("flush_cnt", 32'(dut.count), 32'd0);
    chk("flush_v0", 32'(bus.out0_valid), 32'd0);
    chk("flush_fa", 32'(bus.fetch_allow), 32'd1);

    // Advance head/tail to 24, then enqueue across the wrap.
    for (int k = 0; k < 6; k++) begin
      cyc(1, 32'h600, 0, 0, 0, 2'b00, 0);
      cyc(0, 0, 1, 4, 32'h6600, 2'b00, 0);
      cyc(0, 0, 0, 0, 0, 2'b11, 0);
      cyc(0, 0, 0, 0, 0, 2'b11, 0);
    end
    chk("pre_wrap_cnt", 32'(dut.count), 32'd0);
    cyc(1, 32'h7000, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 1, 4, 32'h6000, 2'b00, 0);
    chk("pre_wrap_tail", 32'(dut.tail), 32'd28);
    cyc(1, 32'h8000, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 1, 8, 32'h9000, 2'b11, 0);
    chk("wrap_cnt", 32'(dut.count), 32'd10);
    chk("wrap_tail", 32'(dut.tail), 32'd4);
    slots("wrap_a", 32'h6002, 32'h7008, 32'h6003, 32'h700C);
    cyc(0, 0, 0, 0, 0, 2'b11, 0);
    slots("wrap_b", 32'h9000, 32'h8000, 32'h9001, 32'h8004);
    cyc(0, 0, 0, 0, 0, 2'b11, 0);
    slots("wrap_c", 32'h9002, 32'h8008, 32'h9003, 32'h800C);
    cyc(0, 0, 0, 0, 0, 2'b11, 0);
    slots("wrap_d", 32'h9004, 32'h8010, 32'h9005, 32'h8014);

    // Asynchronous reset between edges with 10 entries held.
    cyc(1, 32'hA00, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 1, 6, 32'hAA00, 2'b00, 0);
    chk("arst_pre_cnt", 32'(dut.count), 32'd10);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_v0", 32'(bus.out0_valid), 32'd0);
    chk("arst_cnt", 32'(dut.count), 32'd0);
    chk("arst_i0", bus.out0_inst, 32'd0);
    #1;
    resetn = 1'b1;
    #1;
    chk("arst_fa", 32'(bus.fetch_allow), 32'd1);
    chk("arst_pend", 32'(dut.pend), 32'd0);
    @(posedge clk); #2;

    // Flush with two requests outstanding: both responses are dropped.
    cyc(1, 32'hA000, 0, 0, 0, 2'b00, 0);
    cyc(1, 32'hB000, 0, 0, 0, 2'b00, 0);
    chk("drop_pend2_fa", 32'(bus.fetch_allow), 32'd0);
    cyc(0, 0, 0, 0, 0, 2'b00, 1);
    chk("drop_flush_v0", 32'(bus.out0_valid), 32'd0);
    chk("drop_cnt", 32'(dut.drop), 32'd2);
    cyc(0, 0, 1, 8, 32'hEE00, 2'b00, 0);
    chk("drop1_cnt", 32'(dut.count), 32'd0);
    chk("drop1_v0", 32'(bus.out0_valid), 32'd0);
    cyc(1, 32'hC000, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 1, 8, 32'hEF00, 2'b00, 0);
    chk("drop2_cnt", 32'(dut.count), 32'd0);
    cyc(0, 0, 1, 2, 32'hD000, 2'b00, 0);
    chk("post_drop_cnt", 32'(dut.count), 32'd2);
    slots("post_drop", 32'hD000, 32'hC000, 32'hD001, 32'hC004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
